id_opimm_stage: RTL and testbench
=================================

// Module: id_opimm_stage
// PURPOSE
//  Registered, parametrised OP-IMM (I-type ALU) decode stage between IF and EX.
//  Decodes ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI for XLEN 32 or 64.
//  Reads rs1, bypasses write-back data, builds the immediate or shift-amount operand,
//  flags illegal encodings and holds the result in a valid/ready pipeline register.
// PARAMETERS
//  XLEN     32  datapath width; only 32 or 64 are legal
//  RADDR_W  5   register-file address width
//  SHAMT_W  $clog2(XLEN)  shift-amount width (5 or 6); derived, do not override
// PORTS
//  clk          in   1        clock; all state updates on rising edge
//  rst          in   1        synchronous reset, active-high
//  inst_valid_i in   1        upstream instruction valid
//  inst_ready_o out  1        stage can accept this cycle
//  inst_i       in   32       instruction word
//  reg1_raddr_o out  RADDR_W  rs1 read address (combinational from inst_i)
//  reg1_rdata_i in   XLEN     rs1 read data, same cycle
//  wb_we_i      in   1        write-back write enable (bypass source)
//  wb_waddr_i   in   RADDR_W  write-back address
//  wb_wdata_i   in   XLEN     write-back data
//  flush_i      in   1        kill held and incoming instruction
//  valid_o      out  1        decoded instruction valid to EX
//  ready_i      in   1        EX accepts this cycle
//  op1_o        out  XLEN     operand 1 (rs1 value)
//  op2_o        out  XLEN     operand 2 (sign-extended imm or zero-extended shamt)
//  alu_op_o     out  4        {inst[30] for SRLI/SRAI else 0, funct3}
//  reg_we_o     out  1        write rd
//  reg_waddr_o  out  RADDR_W  rd
//  illegal_o    out  1        illegal encoding; reg_we_o is 0 when set
// BEHAVIOUR
//  - Reset: valid_o=0; op1_o, op2_o, alu_op_o, reg_we_o, reg_waddr_o, illegal_o = 0.
//  - inst_ready_o = !valid_o || ready_i (combinational).
//  - Accept when inst_valid_i && inst_ready_o. Outputs register the next edge (latency 1).
//  - When not accepting and valid_o && !ready_i, all outputs hold stable.
//  - If valid_o && ready_i and there is no accept, valid_o goes to 0 next edge.
//  - flush_i has priority over accept: valid_o goes to 0 next edge and the incoming beat
//    is dropped. inst_ready_o is still reported as computed, so upstream treats the
//    beat as consumed.
//  - reg1_raddr_o = inst_i[19:15] at all times.
//  - op1: 0 if rs1==0; else wb_wdata_i if wb_we_i && wb_waddr_i==rs1; else reg1_rdata_i.
//  - op2 for non-shift ops: inst[31:20] sign-extended to XLEN.
//  - op2 for shifts: inst[20+SHAMT_W-1:20] zero-extended to XLEN.
//  - Illegal when any of the following holds:
//      opcode != 7'b0010011;
//      SLLI with inst[31:20+SHAMT_W] != 0;
//      SRLI/SRAI with inst[31:20+SHAMT_W] not equal to 0 (SRLI) or 0b0100..0 (SRAI);
//      XLEN=32 with inst[25]=1 on any shift.
//  - For an illegal instruction: valid_o=1, illegal_o=1, reg_we_o=0; op1/op2/alu_op are
//    don't-care, but still registered.
//  - Legal instruction: reg_we_o=1 and reg_waddr_o=inst[11:7]. rd==0 is still written;
//    the register file ignores x0.
//  - Reset mid-transfer discards the held instruction. No replay.
// TESTING
//  1. rst high 2 cycles -> valid_o=0, all outputs 0, inst_ready_o=1.
//  2. ADDI x5,x1,-1 (0xFFF08293), x1=7 -> next cycle op1=7,
//     op2=0xFFFFFFFF, alu_op=0000, waddr=5, we=1.
//  3. XLEN=64: SRAI x3,x2,33 (0x4211_5193) -> op2=33, alu_op=1101, illegal=0.
//     XLEN=32: same word -> illegal=1, we=0.
//  4. Bypass: wb_we=1, wb_waddr=1, wb_wdata=0x55 with ADDI rs1=1 -> op1=0x55.
//     Same stimulus with rs1=0 -> op1=0.
//  5. ready_i=0 for 3 cycles with valid_o=1 -> outputs stable, inst_ready_o=0.
//     ready_i=1 -> next instruction loads the following cycle.
//  6. flush_i=1 together with an accepted beat -> valid_o=0 next cycle.
//     Opcode 0110011 -> illegal_o=1.

Source files
------------

// File: rtl/id_opimm_stage.sv
// rtl/id_opimm_stage.sv - registered OP-IMM decode stage between IF and EX
//
// Purpose:
//   Decodes the I-type ALU group (ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI)
//   for XLEN 32 or 64. It reads rs1 with write-back bypass, builds the
//   immediate or shift-amount operand, flags illegal encodings and holds the
//   result in a single valid/ready pipeline register.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   inst_valid_i/     upstream instruction handshake; inst_ready_o is
//   inst_ready_o      combinational (!valid_o || ready_i)
//   inst_i            32-bit instruction word
//   reg1_raddr_o      rs1 read address, combinational from inst_i
//   reg1_rdata_i      rs1 read data, same cycle
//   wb_we_i/wb_waddr_i/wb_wdata_i  write-back port used as bypass source
//   flush_i           kills the held and the incoming instruction
//   valid_o/ready_i   downstream handshake to EX
//   op1_o, op2_o      operands (rs1 value, immediate or shamt)
//   alu_op_o          {inst[30] for SRLI/SRAI else 0, funct3}
//   reg_we_o          write rd (0 for illegal encodings)
//   reg_waddr_o       rd
//   illegal_o         illegal encoding flag

module id_opimm_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_valid_i,
  output logic               inst_ready_o,
  input  logic [31:0]        inst_i,
  output logic [RADDR_W-1:0] reg1_raddr_o,
  input  logic [XLEN-1:0]    reg1_rdata_i,
  input  logic               wb_we_i,
  input  logic [RADDR_W-1:0] wb_waddr_i,
  input  logic [XLEN-1:0]    wb_wdata_i,
  input  logic               flush_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [XLEN-1:0]    op1_o,
  output logic [XLEN-1:0]    op2_o,
  output logic [3:0]         alu_op_o,
  output logic               reg_we_o,
  output logic [RADDR_W-1:0] reg_waddr_o,
  output logic               illegal_o
);

  // Bits of the immediate field above the shift amount.
  localparam int UW = 12 - SHAMT_W;

  localparam logic [6:0]    OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0]    F3_SLL     = 3'b001;
  localparam logic [2:0]    F3_SR      = 3'b101;
  // SRAI encodes as upper field 0b0100..0 (only inst[30] set).
  localparam logic [UW-1:0] SRAI_UPPER = {1'b0, 1'b1, {(UW-2){1'b0}}};

  // ---------------------------------------------------------------- decode
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [4:0]         rs1;
  logic [4:0]         rd;
  logic [UW-1:0]      upper;
  logic [SHAMT_W-1:0] shamt;
  logic               is_sll;
  logic               is_sr;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign shamt  = inst_i[20 +: SHAMT_W];
  assign upper  = inst_i[31:20+SHAMT_W];
  assign is_sll = (funct3 == F3_SLL);
  assign is_sr  = (funct3 == F3_SR);

  assign reg1_raddr_o = RADDR_W'(rs1);

  logic            dec_illegal;
  logic [XLEN-1:0] dec_op1;
  logic [XLEN-1:0] dec_op2;
  logic [3:0]      dec_alu_op;

  always_comb begin
    dec_illegal = (opcode != OPC_OP_IMM);
    if (is_sll && (upper != '0)) begin
      dec_illegal = 1'b1;
    end
    if (is_sr && (upper != '0) && (upper != SRAI_UPPER)) begin
      dec_illegal = 1'b1;
    end
    // RV32 has no shamt[5]; already covered by the upper check, kept explicit.
    if ((XLEN == 32) && (is_sll || is_sr) && inst_i[25]) begin
      dec_illegal = 1'b1;
    end
  end

  always_comb begin
    if (rs1 == 5'd0) begin
      dec_op1 = '0;
    end else if (wb_we_i && (wb_waddr_i == RADDR_W'(rs1))) begin
      dec_op1 = wb_wdata_i;
    end else begin
      dec_op1 = reg1_rdata_i;
    end
  end

  always_comb begin
    if (is_sll || is_sr) begin
      dec_op2 = {{(XLEN-SHAMT_W){1'b0}}, shamt};
    end else begin
      dec_op2 = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    end
  end

  assign dec_alu_op = {is_sr & inst_i[30], funct3};

  // ------------------------------------------------------ pipeline register
  logic               valid_q,     valid_d;
  logic [XLEN-1:0]    op1_q,       op1_d;
  logic [XLEN-1:0]    op2_q,       op2_d;
  logic [3:0]         alu_op_q,    alu_op_d;
  logic               reg_we_q,    reg_we_d;
  logic [RADDR_W-1:0] reg_waddr_q, reg_waddr_d;
  logic               illegal_q,   illegal_d;
  logic               accept;

  assign inst_ready_o = !valid_q || ready_i;
  assign accept       = inst_valid_i && inst_ready_o;

  always_comb begin
    valid_d     = valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    alu_op_d    = alu_op_q;
    reg_we_d    = reg_we_q;
    reg_waddr_d = reg_waddr_q;
    illegal_d   = illegal_q;

    if (flush_i) begin
      // Upstream still sees inst_ready_o, so the incoming beat is consumed and lost.
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d     = 1'b1;
      op1_d       = dec_op1;
      op2_d       = dec_op2;
      alu_op_d    = dec_alu_op;
      reg_we_d    = !dec_illegal;
      reg_waddr_d = RADDR_W'(rd);
      illegal_d   = dec_illegal;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      alu_op_q    <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      alu_op_q    <= alu_op_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      illegal_q   <= illegal_d;
    end
  end

  assign valid_o     = valid_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign alu_op_o    = alu_op_q;
  assign reg_we_o    = reg_we_q;
  assign reg_waddr_o = reg_waddr_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_id_opimm_stage.sv
// tb/tb_id_opimm_stage.sv - directed self-checking bench for id_opimm_stage
module tb_id_opimm_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        flush;
  logic        ready;

  logic        inst_ready;
  logic [4:0]  raddr;
  logic        valid;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  alu_op;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic        illegal;

  logic        inst_ready64;
  logic [4:0]  raddr64;
  logic        valid64;
  logic [63:0] op1_64;
  logic [63:0] op2_64;
  logic [3:0]  alu_op64;
  logic        reg_we64;
  logic [4:0]  reg_waddr64;
  logic        illegal64;

  always #5 clk = ~clk;

  id_opimm_stage #(.XLEN(32)) u_dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid), .inst_ready_o(inst_ready), .inst_i(inst),
    .reg1_raddr_o(raddr), .reg1_rdata_i(rdata),
    .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
    .flush_i(flush), .valid_o(valid), .ready_i(ready),
    .op1_o(op1), .op2_o(op2), .alu_op_o(alu_op),
    .reg_we_o(reg_we), .reg_waddr_o(reg_waddr), .illegal_o(illegal)
  );

  id_opimm_stage #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid), .inst_ready_o(inst_ready64), .inst_i(inst),
    .reg1_raddr_o(raddr64), .reg1_rdata_i({32'h0, rdata}),
    .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i({32'h0, wb_wdata}),
    .flush_i(flush), .valid_o(valid64), .ready_i(ready),
    .op1_o(op1_64), .op2_o(op2_64), .alu_op_o(alu_op64),
    .reg_we_o(reg_we64), .reg_waddr_o(reg_waddr64), .illegal_o(illegal64)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rdata;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        exp_ill;
    logic [3:0]  exp_alu;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_op1;
    logic [31:0] exp_op2;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] i, input logic [31:0] rd,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic ill, input logic [3:0] alu, input logic [4:0] wadr,
                              input logic [31:0] o1, input logic [31:0] o2);
    vec_t v;
    v.inst = i; v.rdata = rd; v.wb_we = we; v.wb_waddr = wa; v.wb_wdata = wd;
    v.exp_ill = ill; v.exp_alu = alu; v.exp_waddr = wadr; v.exp_op1 = o1; v.exp_op2 = o2;
    return v;
  endfunction

  task automatic idle_inputs();
    inst_valid = 1'b0; inst = 32'h0; rdata = 32'h0; wb_we = 1'b0;
    wb_waddr = 5'd0; wb_wdata = 32'h0; flush = 1'b0; ready = 1'b1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] rd);
    inst_valid = 1'b1; inst = i; rdata = rd;
    wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0;
  endtask

  vec_t vq[$];

  initial begin
    // ADDI x5,x1,-1 with x1=7
    vq.push_back(mk(32'hFFF08293, 32'd7, 1'b0, 5'd0, 32'h0, 1'b0, 4'b0000, 5'd5, 32'd7, 32'hFFFFFFFF));
    // same, bypass from write-back of x1
    vq.push_back(mk(32'hFFF08293, 32'd7, 1'b1, 5'd1, 32'h55, 1'b0, 4'b0000, 5'd5, 32'h55, 32'hFFFFFFFF));
    // ADDI x5,x0,-1: rs1=0 wins over a write-back to x0
    vq.push_back(mk(32'hFFF00293, 32'd7, 1'b1, 5'd0, 32'h55, 1'b0, 4'b0000, 5'd5, 32'h0, 32'hFFFFFFFF));
    // SLLI x6,x7,31, write-back to a different register
    vq.push_back(mk(32'h01F39313, 32'h1234, 1'b1, 5'd8, 32'hDEAD, 1'b0, 4'b0001, 5'd6, 32'h1234, 32'd31));
    // SRLI x8,x9,4
    vq.push_back(mk(32'h0044D413, 32'hABCD, 1'b0, 5'd0, 32'h0, 1'b0, 4'b0101, 5'd8, 32'hABCD, 32'd4));
    // SRAI x8,x9,4
    vq.push_back(mk(32'h4044D413, 32'hABCD, 1'b0, 5'd0, 32'h0, 1'b0, 4'b1101, 5'd8, 32'hABCD, 32'd4));
    // ANDI x10,x11,0x7FF
    vq.push_back(mk(32'h7FF5F513, 32'h5, 1'b0, 5'd0, 32'h0, 1'b0, 4'b0111, 5'd10, 32'h5, 32'h7FF));
    // SLTIU x1,x2,-2048
    vq.push_back(mk(32'h80013093, 32'h9, 1'b0, 5'd0, 32'h0, 1'b0, 4'b0011, 5'd1, 32'h9, 32'hFFFFF800));
    // ORI x2,x3,0xF0
    vq.push_back(mk(32'h0F01E113, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0, 4'b0110, 5'd2, 32'h77, 32'hF0));
    // illegal: ADD (opcode 0110011)
    vq.push_back(mk(32'h003100B3, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1, 4'b0000, 5'd0, 32'h0, 32'h0));
    // illegal: SLLI shamt 32 on RV32
    vq.push_back(mk(32'h02039313, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1, 4'b0000, 5'd0, 32'h0, 32'h0));
    // illegal: SRAI with stray upper bit 29
    vq.push_back(mk(32'h6044D413, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1, 4'b0000, 5'd0, 32'h0, 32'h0));
    // illegal on RV32: SRAI x3,x2,33
    vq.push_back(mk(32'h42115193, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1, 4'b0000, 5'd0, 32'h0, 32'h0));

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset valid_o", valid, 0);
    check("reset op1_o", op1, 0);
    check("reset op2_o", op2, 0);
    check("reset alu_op_o", alu_op, 0);
    check("reset reg_we_o", reg_we, 0);
    check("reset reg_waddr_o", reg_waddr, 0);
    check("reset illegal_o", illegal, 0);
    check("reset inst_ready_o", inst_ready, 1);

    // Back-to-back table vectors, one per cycle, ready_i held high.
    foreach (vq[k]) begin
      @(negedge clk);
      inst_valid = 1'b1; inst = vq[k].inst; rdata = vq[k].rdata;
      wb_we = vq[k].wb_we; wb_waddr = vq[k].wb_waddr; wb_wdata = vq[k].wb_wdata;
      #1;
      check($sformatf("v%0d raddr", k), raddr, {59'h0, vq[k].inst[19:15]});
      check($sformatf("v%0d inst_ready", k), inst_ready, 1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d valid", k), valid, 1);
      check($sformatf("v%0d illegal", k), illegal, {63'h0, vq[k].exp_ill});
      check($sformatf("v%0d reg_we", k), reg_we, {63'h0, !vq[k].exp_ill});
      if (!vq[k].exp_ill) begin
        check($sformatf("v%0d op1", k), op1, {32'h0, vq[k].exp_op1});
        check($sformatf("v%0d op2", k), op2, {32'h0, vq[k].exp_op2});
        check($sformatf("v%0d alu_op", k), alu_op, {60'h0, vq[k].exp_alu});
        check($sformatf("v%0d reg_waddr", k), reg_waddr, {59'h0, vq[k].exp_waddr});
      end
    end

    // The last vector was SRAI x3,x2,33: legal on the 64-bit instance.
    check("rv64 srai valid", valid64, 1);
    check("rv64 srai illegal", illegal64, 0);
    check("rv64 srai reg_we", reg_we64, 1);
    check("rv64 srai op2", op2_64, 64'd33);
    check("rv64 srai alu_op", alu_op64, 4'b1101);
    check("rv64 srai waddr", reg_waddr64, 5'd3);

    // No new beat with ready_i high: valid drops.
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    check("drain valid", valid, 0);

    // Stall: hold instruction A for 3 cycles while B waits.
    @(negedge clk);
    drive(32'hFFF08293, 32'd7);          // A: ADDI x5,x1,-1
    @(posedge clk); #1;
    check("stall A loaded", op1, 32'd7);
    @(negedge clk);
    ready = 1'b0;
    drive(32'h7FF5F513, 32'h5);          // B: ANDI x10,x11,0x7FF
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d inst_ready", c), inst_ready, 0);
      @(posedge clk); #1;
      check($sformatf("stall%0d valid", c), valid, 1);
      check($sformatf("stall%0d op1", c), op1, 32'd7);
      check($sformatf("stall%0d op2", c), op2, 32'hFFFFFFFF);
      check($sformatf("stall%0d waddr", c), reg_waddr, 5'd5);
      @(negedge clk);
    end
    ready = 1'b1;
    #1;
    check("release inst_ready", inst_ready, 1);
    @(posedge clk); #1;
    check("B valid", valid, 1);
    check("B op1", op1, 32'h5);
    check("B op2", op2, 32'h7FF);
    check("B waddr", reg_waddr, 5'd10);

    // Flush together with an accepted beat.
    @(negedge clk);
    flush = 1'b1;
    drive(32'h0F01E113, 32'h77);
    #1;
    check("flush inst_ready", inst_ready, 1);
    @(posedge clk); #1;
    check("flush valid", valid, 0);
    check("flush drops beat op1", op1, 32'h5);

    // Flush while holding a stalled instruction.
    @(negedge clk);
    flush = 1'b0;
    drive(32'h0F01E113, 32'h77);
    @(posedge clk); #1;
    check("pre-flush valid", valid, 1);
    @(negedge clk);
    ready = 1'b0; inst_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    check("flush held valid", valid, 0);

    // Reset mid-transfer discards the held instruction.
    @(negedge clk);
    flush = 1'b0; ready = 1'b0;
    drive(32'h80013093, 32'h9);
    @(posedge clk); #1;
    check("pre-reset valid", valid, 1);
    @(negedge clk);
    inst_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("mid reset valid", valid, 0);
    check("mid reset op2", op2, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
